// File: rtl/bus_rr_arbiter4_pkg.sv
// Shared types, constants and helpers for the 4-way round-robin bus arbiter.
package bus_arb_pkg;

    localparam int NUM_REQ = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Encode a one-hot (or all-zero) 4-bit vector into a 2-bit index.
    // An all-zero input maps to index 0.
    function automatic logic [1:0] onehot2idx(input logic [NUM_REQ-1:0] oh);
        logic [1:0] idx;
        idx[0] = oh[1] | oh[3];
        idx[1] = oh[2] | oh[3];
        return idx;
    endfunction

endpackage

// File: rtl/bus_rr_arbiter4_if.sv
// Producer/consumer side of the arbiter: four data buses, requests,
// grants/acks and the registered output word with its handshake.
interface bus_rr_arbiter4_if #(
    parameter int BUS_WIDTH = 8
);
    import bus_arb_pkg::*;

    logic [BUS_WIDTH-1:0] A;
    logic [BUS_WIDTH-1:0] B;
    logic [BUS_WIDTH-1:0] C;
    logic [BUS_WIDTH-1:0] D;
    logic [NUM_REQ-1:0]   REQ;
    logic                 READY;
    logic [NUM_REQ-1:0]   GNT;
    logic [1:0]           SEL;
    logic [NUM_REQ-1:0]   ACK;
    logic [BUS_WIDTH-1:0] Y;
    logic                 Y_VALID;

    // Arbiter side.
    modport master (
        input  A, B, C, D, REQ, READY,
        output GNT, SEL, ACK, Y, Y_VALID
    );

    // Producers and consumer side.
    modport slave (
        output A, B, C, D, REQ, READY,
        input  GNT, SEL, ACK, Y, Y_VALID
    );

endinterface

// File: rtl/bus_rr_arbiter4_rr_pick4.sv
// Combinational round-robin picker: returns the first requesting index
// found when scanning ptr, ptr+1, ... modulo 4.
module rr_pick4
    import bus_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         ptr,
    output logic [1:0]         winner,
    output logic               any_req
);

    logic [NUM_REQ-1:0] rot;
    logic [NUM_REQ-1:0] first;

    // Rotate requests so that bit 0 is the current highest-priority index.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_rot
            assign rot[gi] = req[ptr + 2'(gi)];
        end
    endgenerate

    // Isolate the lowest set bit of the rotated vector, then undo the rotation.
    assign first   = rot & (~rot + NUM_REQ'(1));
    assign winner  = ptr + onehot2idx(first);
    assign any_req = |req;

endmodule

// File: rtl/bus_rr_arbiter4.sv
// Round-robin arbiter and registered output stage for four requesters
// sharing one bus. Grants are held up to MAX_HOLD transfers, and every
// release passes through one IDLE cycle before the next grant.
module bus_rr_arbiter4
    import bus_arb_pkg::*;
#(
    parameter int BUS_WIDTH = 8,
    parameter int MAX_HOLD  = 4
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    bus_rr_arbiter4_if.master    bus
);

    localparam int               HOLD_W    = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_t               state_reg, state_next;
    logic [1:0]           ptr_reg, ptr_next;
    logic [HOLD_W-1:0]    hold_reg, hold_next;
    logic [NUM_REQ-1:0]   gnt_reg, gnt_next;
    logic [1:0]           sel_reg, sel_next;
    logic [BUS_WIDTH-1:0] y_reg, y_next;
    logic                 y_valid_reg, y_valid_next;

    logic                 cap_en;
    logic                 transfer;
    logic [NUM_REQ-1:0]   ack;
    logic [BUS_WIDTH-1:0] sel_word;
    logic [1:0]           winner;
    logic                 any_req;

    rr_pick4 u_pick (
        .req     (bus.REQ),
        .ptr     (ptr_reg),
        .winner  (winner),
        .any_req (any_req)
    );

    // The output register can take a word when empty or being drained.
    assign cap_en = !y_valid_reg | bus.READY;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_ack
            assign ack[gi] = gnt_reg[gi] & bus.REQ[gi] & cap_en;
        end
    endgenerate

    assign transfer = |ack;

    // 4:1 data select driven by the registered grant index.
    always_comb begin
        sel_word = bus.A;
        case (sel_reg)
            2'd0:    sel_word = bus.A;
            2'd1:    sel_word = bus.B;
            2'd2:    sel_word = bus.C;
            default: sel_word = bus.D;
        endcase
    end

    // Next-state logic for arbitration, hold counting and the output word.
    always_comb begin
        state_next   = state_reg;
        ptr_next     = ptr_reg;
        hold_next    = hold_reg;
        gnt_next     = gnt_reg;
        sel_next     = sel_reg;
        y_next       = y_reg;
        y_valid_next = y_valid_reg;

        // A transfer overrides the drain so back-to-back words keep Y_VALID high.
        if (transfer) begin
            y_next       = sel_word;
            y_valid_next = 1'b1;
        end else if (y_valid_reg && bus.READY) begin
            y_valid_next = 1'b0;
        end

        case (state_reg)
            IDLE: begin
                if (any_req) begin
                    state_next = GRANT;
                    gnt_next   = NUM_REQ'(1) << winner;
                    sel_next   = winner;
                    hold_next  = '0;
                end
            end
            GRANT: begin
                if (transfer) begin
                    hold_next = hold_reg + HOLD_W'(1);
                end
                // Release when the owner drops, or after its last allowed word.
                if (!bus.REQ[sel_reg] || (transfer && hold_reg == HOLD_LAST)) begin
                    state_next = IDLE;
                    gnt_next   = '0;
                    ptr_next   = sel_reg + 2'd1;
                end
            end
            default: begin
                state_next = IDLE;
                gnt_next   = '0;
            end
        endcase
    end

    // State registers with asynchronous clear.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg   <= IDLE;
            ptr_reg     <= '0;
            hold_reg    <= '0;
            gnt_reg     <= '0;
            sel_reg     <= '0;
            y_reg       <= '0;
            y_valid_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ptr_reg     <= ptr_next;
            hold_reg    <= hold_next;
            gnt_reg     <= gnt_next;
            sel_reg     <= sel_next;
            y_reg       <= y_next;
            y_valid_reg <= y_valid_next;
        end
    end

    assign bus.GNT     = gnt_reg;
    assign bus.SEL     = sel_reg;
    assign bus.ACK     = ack;
    assign bus.Y       = y_reg;
    assign bus.Y_VALID = y_valid_reg;

endmodule
